// File: rtl/if_prefetch_if.sv
// Fetch-unit bus bundle: the memory read handshake, the decode-side valid/ready port,
// and the redirect control.
interface if_prefetch_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LVL_W  = 3
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_data;
  logic              mfc;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [LVL_W-1:0]  level;

  modport master (
    output mem_addr, mem_en, mem_rw, inst_valid, inst, inst_pc, level,
    input  mem_data, mfc, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_addr, mem_en, mem_rw, inst_valid, inst, inst_pc, level,
    output mem_data, mfc, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/if_prefetch.sv
// Instruction-fetch unit: owns the fetch PC, issues one memory read at a time and buffers
// fetched words in a DEPTH-entry queue for the decode stage. A redirect flushes the queue.
module if_prefetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
  input logic           clk_i,
  input logic           rst_i,
  if_prefetch_if.master bus_io
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_en_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [LvlW-1:0]   level_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] ipc_q  [DEPTH];

  logic mfc_hit;
  logic inst_valid;
  logic push;
  logic pop;

  // mfc only counts while a request is actually on the bus.
  always_comb begin
    mfc_hit    = mem_en_q & bus_io.mfc;
    inst_valid = (level_q != '0);
    push       = (state_q == StReq) & mfc_hit & ~bus_io.redirect;
    pop        = inst_valid & bus_io.inst_ready & ~bus_io.redirect;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_en_q   <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        ipc_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= bus_io.mem_data;
        ipc_q[wr_ptr_q]  <= pc_q;
      end

      if (bus_io.redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        level_q  <= '0;
        pc_q     <= bus_io.redirect_pc;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PtrW'(1);
          pc_q     <= pc_q + PC_STEP;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        if (push != pop) begin
          level_q <= push ? level_q + LvlW'(1) : level_q - LvlW'(1);
        end
      end

      // A request, once raised, is held with a stable address until mfc.
      unique case (state_q)
        StIdle: begin
          if (!bus_io.redirect && (level_q < LvlW'(DEPTH))) begin
            state_q    <= StReq;
            mem_en_q   <= 1'b1;
            mem_addr_q <= pc_q;
          end
        end
        StReq: begin
          if (mfc_hit) begin
            state_q  <= StIdle;
            mem_en_q <= 1'b0;
          end else if (bus_io.redirect) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (mfc_hit) begin
            state_q  <= StIdle;
            mem_en_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          mem_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.mem_addr   = mem_addr_q;
  assign bus_io.mem_en     = mem_en_q;
  assign bus_io.mem_rw     = 1'b1;
  assign bus_io.inst_valid = inst_valid;
  assign bus_io.inst       = inst_valid ? data_q[rd_ptr_q] : '0;
  assign bus_io.inst_pc    = inst_valid ? ipc_q[rd_ptr_q] : '0;
  assign bus_io.level      = level_q;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed scenarios plus random redirect/ready/latency traffic,
// all checked every cycle against a queue-based reference model.
module tb_if_prefetch;

  localparam int unsigned DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   started = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  if_prefetch_if #(.ADDR_W(16), .DATA_W(16), .LVL_W(3)) bus ();
  if_prefetch_if #(.ADDR_W(16), .DATA_W(16), .LVL_W(3)) bus_w ();

  if_prefetch #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .RESET_PC(16'h0000),
                .PC_STEP(16'h0001)) dut (
    .clk_i (clk),
    .rst_i (reset),
    .bus_io(bus.master)
  );

  if_prefetch #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .RESET_PC(16'hFFFE),
                .PC_STEP(16'h0001)) dut_w (
    .clk_i (clk),
    .rst_i (reset),
    .bus_io(bus_w.master)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Wrap instance: zero-latency memory, no redirects.
  logic        rdy_w = 1'b0;
  logic [15:0] wq[$];
  assign bus_w.mfc         = bus_w.mem_en;
  assign bus_w.mem_data    = bus_w.mem_addr ^ 16'hA500;
  assign bus_w.inst_ready  = rdy_w;
  assign bus_w.redirect    = 1'b0;
  assign bus_w.redirect_pc = 16'h0000;

  always @(negedge clk) begin
    if (started && !reset && bus_w.mem_en && wq.size() < 3) wq.push_back(bus_w.mem_addr);
  end

  // Memory model for the main instance.
  int mem_lat  = 2;
  int mem_cnt  = 0;
  bit rand_lat = 1'b0;
  bit spurious = 1'b0;

  initial begin
    bus.mfc         = 1'b0;
    bus.mem_data    = '0;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
  end

  always @(negedge clk) begin
    if (bus.mem_en) begin
      if (mem_cnt >= mem_lat) begin
        bus.mfc      = 1'b1;
        bus.mem_data = bus.mem_addr ^ 16'hA500;
      end else begin
        bus.mfc      = 1'b0;
        bus.mem_data = 16'($urandom);
        mem_cnt++;
      end
    end else begin
      mem_cnt      = 0;
      if (rand_lat) mem_lat = $urandom_range(0, 3);
      bus.mfc      = spurious && ($urandom_range(0, 3) == 0);
      bus.mem_data = 16'($urandom);
    end
  end

  // Reference model: the queue contents plus the single outstanding request.
  typedef struct packed { logic [15:0] d; logic [15:0] pc; } ent_t;
  ent_t        mq[$];
  logic [15:0] m_pc   = 16'h0000;
  logic [15:0] m_addr = 16'h0000;
  bit          m_busy = 1'b0;
  bit          m_stale = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_pc    = 16'h0000;
      m_addr  = 16'h0000;
      m_busy  = 1'b0;
      m_stale = 1'b0;
    end else begin
      bit do_pop;
      bit do_push;
      do_pop  = bus.inst_ready && (mq.size() != 0) && !bus.redirect;
      do_push = 1'b0;
      if (m_busy) begin
        if (bus.mfc) begin
          m_busy  = 1'b0;
          do_push = !m_stale && !bus.redirect;
        end else if (bus.redirect) begin
          m_stale = 1'b1;
        end
      end else if (!bus.redirect && mq.size() < DEPTH) begin
        m_busy  = 1'b1;
        m_stale = 1'b0;
        m_addr  = m_pc;
      end
      if (bus.redirect) begin
        mq.delete();
        m_pc = bus.redirect_pc;
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back({m_addr ^ 16'hA500, m_addr});
          m_pc = m_pc + 16'h0001;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      check("mem_en", {31'd0, bus.mem_en}, {31'd0, m_busy});
      if (m_busy) check("mem_addr", {16'd0, bus.mem_addr}, {16'd0, m_addr});
      check("mem_rw", {31'd0, bus.mem_rw}, 32'd1);
      check("level", {29'd0, bus.level}, mq.size());
      check("inst_valid", {31'd0, bus.inst_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
        check("inst", {16'd0, bus.inst}, {16'd0, mq[0].d});
        check("inst_pc", {16'd0, bus.inst_pc}, {16'd0, mq[0].pc});
      end else begin
        check("inst_idle", {16'd0, bus.inst}, 32'd0);
        check("inst_pc_idle", {16'd0, bus.inst_pc}, 32'd0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [15:0] wrap_exp [3];
  logic [15:0] saved_addr;
  logic [15:0] next_pc;
  int          n;

  initial begin
    wrap_exp[0] = 16'hFFFE;
    wrap_exp[1] = 16'hFFFF;
    wrap_exp[2] = 16'h0000;

    #1 reset = 1'b1;
    repeat (3) step();
    check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("rst_mem_rw", {31'd0, bus.mem_rw}, 32'd1);
    check("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    check("rst_level", {29'd0, bus.level}, 32'd0);
    check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rst_inst", {16'd0, bus.inst}, 32'd0);
    check("rst_inst_pc", {16'd0, bus.inst_pc}, 32'd0);
    check("rst_wrap_addr", {16'd0, bus_w.mem_addr}, 32'h0000FFFE);
    reset   = 1'b0;
    started = 1'b1;

    // Fill with the consumer stalled.
    n = 0;
    while (bus.level != 3'd4 && n < 60) begin step(); n++; end
    check("fill_level", {29'd0, bus.level}, 32'd4);
    check("fill_head_inst", {16'd0, bus.inst}, 32'h0000A500);
    check("fill_head_pc", {16'd0, bus.inst_pc}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("full_mem_en", {31'd0, bus.mem_en}, 32'd0);
    end

    // Wrap instance: fetch order and head PCs across the address wrap.
    check("wrap_addr_count", wq.size(), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < wq.size()) check("wrap_addr", {16'd0, wq[k]}, {16'd0, wrap_exp[k]});
    end
    for (int k = 0; k < 3; k++) begin
      check("wrap_valid", {31'd0, bus_w.inst_valid}, 32'd1);
      check("wrap_inst_pc", {16'd0, bus_w.inst_pc}, {16'd0, wrap_exp[k]});
      check("wrap_inst", {16'd0, bus_w.inst}, {16'd0, wrap_exp[k] ^ 16'hA500});
      rdy_w = 1'b1;
      step();
    end
    rdy_w = 1'b0;

    // Drain continuously: PCs must appear in order with no loss or duplication.
    bus.inst_ready = 1'b1;
    next_pc = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      if (bus.inst_valid) begin
        check("pop_pc", {16'd0, bus.inst_pc}, {16'd0, next_pc});
        check("pop_inst", {16'd0, bus.inst}, {16'd0, next_pc ^ 16'hA500});
        next_pc = next_pc + 16'h0001;
      end
      check("pop_level_max", {31'd0, bus.level <= 3'd4}, 32'd1);
      step();
    end
    check("pop_progress", {31'd0, next_pc >= 16'd4}, 32'd1);

    // Redirect one cycle into a request.
    n = 0;
    while (bus.mem_en && n < 20) begin step(); n++; end
    n = 0;
    while (!bus.mem_en && n < 20) begin step(); n++; end
    check("redir1_req_seen", {31'd0, bus.mem_en}, 32'd1);
    saved_addr       = bus.mem_addr;
    bus.redirect     = 1'b1;
    bus.redirect_pc  = 16'h0100;
    bus.inst_ready   = 1'b0;
    step();
    bus.redirect = 1'b0;
    check("redir1_valid_drop", {31'd0, bus.inst_valid}, 32'd0);
    check("redir1_hold_en", {31'd0, bus.mem_en}, 32'd1);
    check("redir1_hold_addr", {16'd0, bus.mem_addr}, {16'd0, saved_addr});
    n = 0;
    while (!bus.inst_valid && n < 30) begin step(); n++; end
    check("redir1_inst", {16'd0, bus.inst}, 32'h0000A400);
    check("redir1_pc", {16'd0, bus.inst_pc}, 32'h00000100);

    // Redirect + pop at level 3, then redirect again while draining.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0200;
    step();
    bus.redirect = 1'b0;
    n = 0;
    while (!(bus.level == 3'd3 && bus.mem_en) && n < 40) begin step(); n++; end
    check("redir2_level3", {29'd0, bus.level}, 32'd3);
    bus.inst_ready  = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0300;
    step();
    check("redir2_level0", {29'd0, bus.level}, 32'd0);
    check("redir2_valid0", {31'd0, bus.inst_valid}, 32'd0);
    bus.inst_ready  = 1'b0;
    bus.redirect_pc = 16'h0400;
    step();
    bus.redirect = 1'b0;
    check("redir3_level0", {29'd0, bus.level}, 32'd0);
    n = 0;
    while (!bus.inst_valid && n < 30) begin step(); n++; end
    check("redir3_pc", {16'd0, bus.inst_pc}, 32'h00000400);
    check("redir3_inst", {16'd0, bus.inst}, 32'h0000A100);

    // Random traffic: redirects, stalls, variable latency, stray mfc.
    rand_lat = 1'b1;
    spurious = 1'b1;
    for (int i = 0; i < 800; i++) begin
      bus.inst_ready  = 1'($urandom_range(0, 1));
      bus.redirect    = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
      step();
    end
    bus.redirect = 1'b0;
    rand_lat     = 1'b0;
    spurious     = 1'b0;
    repeat (10) step();

    // Asynchronous reset in the middle of a request.
    bus.inst_ready = 1'b1;
    n = 0;
    while (!bus.mem_en && n < 20) begin step(); n++; end
    check("arst_req_seen", {31'd0, bus.mem_en}, 32'd1);
    reset = 1'b1;
    #1;
    check("arst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("arst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("arst_level", {29'd0, bus.level}, 32'd0);
    check("arst_inst", {16'd0, bus.inst}, 32'd0);
    step();
    step();
    reset = 1'b0;
    n = 0;
    while (!bus.mem_en && n < 10) begin step(); n++; end
    check("arst_restart_en", {31'd0, bus.mem_en}, 32'd1);
    check("arst_restart_addr", {16'd0, bus.mem_addr}, 32'd0);
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Parametrised instruction-fetch unit with an internal prefetch queue, the next generation of the discrete IF/PC/MAR/MDR fetch path. It owns the fetch PC, drives the memory read handshake (address, enable, read/write, MFC), buffers up to DEPTH fetched words, and presents them to the decode stage through a valid/ready interface. A redirect input flushes the queue and restarts fetch at a new PC, including while a memory read is still outstanding.

## Interface
- ADDR_W, 16, address and PC width
- DATA_W, 16, instruction word width
- DEPTH, 4, queue entries; power of two, 2..16
- RESET_PC, 0, fetch PC after reset
- PC_STEP, 1, PC increment per fetched word
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- mem_addr  out  ADDR_W  read address, equals fetch PC while mem_en high
- mem_en  out  1  memory request enable
- mem_rw  out  1  constant 1 (read)
- mem_data  in  DATA_W  read data, valid when mfc high
- mfc  in  1  memory function complete
- inst_valid  out  1  queue head valid
- inst  out  DATA_W  head instruction; 0 when inst_valid low
- inst_pc  out  ADDR_W  PC of head instruction; 0 when inst_valid low
- inst_ready  in  1  consumer accepts head this cycle
- redirect  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  new fetch PC
- level  out  $clog2(DEPTH+1)  entries currently queued

## Operation
- Reset values: state IDLE, fetch PC = RESET_PC, mem_en 0, mem_rw 1, mem_addr = RESET_PC, queue empty, level 0, inst_valid 0, inst 0, inst_pc 0.
- FSM states: IDLE, REQ, DRAIN.
- IDLE: mem_en 0. If no redirect and level < DEPTH -> REQ. Otherwise stay.
- REQ: mem_en 1, mem_addr = fetch PC. On mfc: push {mem_data, fetch PC}, fetch PC += PC_STEP, -> IDLE.
- DRAIN: mem_en 1, mem_addr = address of the abandoned request. On mfc: data discarded, no push, -> IDLE.
- Exactly one request outstanding at any time; since issue requires level < DEPTH, a push never overflows.
- Pop: inst_valid && inst_ready at the clock edge removes the head. Push and pop on the same edge leave level unchanged.
- PC arithmetic is modulo 2^ADDR_W; 2^ADDR_W-1 + 1 wraps to 0.
- Redirect has priority over push, pop and issue. On a redirect edge:
  - queue flushed, level 0, fetch PC = redirect_pc;
  - in IDLE -> IDLE;
  - in REQ with mfc the same cycle -> IDLE, data discarded;
  - in REQ without mfc -> DRAIN;
  - in DRAIN -> DRAIN, holding mem_addr.
- Memory request is never aborted: once mem_en rises it stays high, with a stable address, until mfc.
- mfc while mem_en low is ignored.
- Reset asserted mid-request: all state and outputs go to their reset values immediately, asynchronously. The memory side must tolerate a dropped request.

## Timing
- mem_en drops for at least one cycle between requests. Minimum fetch period is 2 cycles (mfc in the first REQ cycle).
- Fetch latency: word visible on inst_valid the cycle after the mfc edge.
- Restart after a redirect from IDLE: mem_en rises 1 cycle later with mem_addr = redirect_pc.
- inst_valid falls the cycle after a redirect edge.
- All outputs are registered or decoded from registered state; no combinational path from inst_ready, redirect or mfc to any output.

## Test plan
Defaults DEPTH=4; the memory model returns mem[a] = a ^ 16'hA500, with mfc 2 cycles after mem_en rises.
- Release reset with inst_ready=0 -> reads at 0,1,2,3; level reaches 4; mem_en stays 0; head inst=16'hA500, inst_pc=0.
- From full, hold inst_ready=1 for 20 cycles -> instructions pop in PC order 0,1,2,... with no gaps, duplicates or losses; level never exceeds 4.
- Redirect to 16'h0100 one cycle after mem_en rises -> inst_valid 0 next cycle; mem_en held until mfc; that word discarded; next request at 16'h0100; first output inst=16'hA400, inst_pc=16'h0100.
- RESET_PC=16'hFFFE -> fetch addresses FFFE, FFFF, 0000 in order; inst_pc follows.
- Redirect and pop on the same edge at level=3, then redirect again while in DRAIN -> level 0; fetch resumes at the second redirect_pc only.
- Assert reset while mem_en=1 before mfc -> mem_en, inst_valid and level go to 0 before the next clk edge; after release, fetch restarts at RESET_PC.
